// File: rtl/fake_bus_memory_if.sv
// -----------------------------------------------------------------------------
// fake_bus_memory_if
//
// Purpose: groups the two CPU bus ports (instruction fetch and data access)
// served by fake_bus_memory into one bundle.
//
// Signals:
//   inst_read, inst_address         fetch request and byte address (master -> slave)
//   inst_rdata, inst_stall          fetched word and fetch-busy flag (slave -> master)
//   data_read, data_write           data read / write requests      (master -> slave)
//   data_address, data_byteenable   byte address and per-lane write enables
//   data_wdata                      lane-aligned write data
//   data_rdata, data_stall          read word and access-busy flag  (slave -> master)
//   data_w                          merged word being committed this cycle (tap)
//
// Modports: master (CPU side / bench), slave (memory side).
// -----------------------------------------------------------------------------
interface fake_bus_memory_if;
    logic        inst_read;
    logic [31:0] inst_address;
    logic [31:0] inst_rdata;
    logic        inst_stall;

    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [3:0]  data_byteenable;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_stall;
    logic [31:0] data_w;

    modport master (
        output inst_read, inst_address,
        input  inst_rdata, inst_stall,
        output data_read, data_write, data_address, data_byteenable, data_wdata,
        input  data_rdata, data_stall, data_w
    );

    modport slave (
        input  inst_read, inst_address,
        output inst_rdata, inst_stall,
        input  data_read, data_write, data_address, data_byteenable, data_wdata,
        output data_rdata, data_stall, data_w
    );
endinterface

// File: rtl/fake_bus_memory.sv
// -----------------------------------------------------------------------------
// fake_bus_memory
//
// Purpose: behavioural memory standing in for block RAM plus interconnect in
// CPU-level simulations. A read-only instruction port reads inst_mem; a
// read/write data port with byte enables reads and writes inst_ram. Both
// arrays are word addressed by address[AW+1:2]; upper bits are ignored so
// accesses wrap. Benches preload/clear the arrays hierarchically; reset never
// touches them.
//
// Parameters:
//   INST_AW  instruction memory address width in words
//   DATA_AW  data memory address width in words
//
// Ports:
//   clk50M   system clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   bus      fake_bus_memory_if.slave (instruction + data ports, data_w tap)
//
// Build option:
//   FAKE_BUS_WAIT_EN  when defined, every access on each port takes one wait
//                     state: stall is high in the request's first cycle and
//                     the access completes at the following edge. When
//                     undefined, accesses complete at the request edge and
//                     both stall outputs are tied low.
// -----------------------------------------------------------------------------
module fake_bus_memory #(
    parameter int INST_AW = 14,
    parameter int DATA_AW = 14
) (
    input  logic               clk50M,
    input  logic               rst,
    fake_bus_memory_if.slave   bus
);

    // Storage: hierarchical names are relied on by benches.
    logic [31:0] inst_mem [0:2**INST_AW-1];
    logic [31:0] inst_ram [0:2**DATA_AW-1];

    logic [INST_AW-1:0] w_inst_idx;
    logic [DATA_AW-1:0] w_data_idx;
    logic [31:0]        w_data_old;
    logic [31:0]        w_data_merged;

    logic               w_inst_go;     // fetch completes at this edge
    logic               w_data_go;     // data access completes at this edge
    logic               w_inst_stall;
    logic               w_data_stall;

    logic [31:0]        r_inst_rdata;
    logic [31:0]        r_data_rdata;

    assign w_inst_idx = bus.inst_address[INST_AW+1:2];
    assign w_data_idx = bus.data_address[DATA_AW+1:2];
    assign w_data_old = inst_ram[w_data_idx];

    // Byte-lane merge of write data over the currently stored word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_data_merged[8*gi +: 8] = bus.data_byteenable[gi]
                                            ? bus.data_wdata[8*gi +: 8]
                                            : w_data_old[8*gi +: 8];
        end
    endgenerate

    // The tap is purely combinational and is not gated by reset, so a bench
    // can still see what a store would have written while rst is high.
    assign bus.data_w = bus.data_write ? w_data_merged : 32'h0;

`ifdef FAKE_BUS_WAIT_EN
    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } wait_state_t;

    wait_state_t r_inst_state, w_inst_state_next;
    wait_state_t r_data_state, w_data_state_next;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            r_inst_state <= ST_IDLE;
            r_data_state <= ST_IDLE;
        end else begin
            r_inst_state <= w_inst_state_next;
            r_data_state <= w_data_state_next;
        end
    end

    // IDLE + request: stall for this cycle. WAIT: the held request completes
    // at the next edge, then the port returns to IDLE so a request still
    // present afterwards is treated as a new access.
    always_comb begin
        w_inst_state_next = r_inst_state;
        w_inst_stall      = 1'b0;
        w_inst_go         = 1'b0;
        w_data_state_next = r_data_state;
        w_data_stall      = 1'b0;
        w_data_go         = 1'b0;

        case (r_inst_state)
            ST_IDLE: begin
                if (bus.inst_read) begin
                    w_inst_stall      = 1'b1;
                    w_inst_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_inst_go         = 1'b1;
                w_inst_state_next = ST_IDLE;
            end
            default: w_inst_state_next = ST_IDLE;
        endcase

        case (r_data_state)
            ST_IDLE: begin
                if (bus.data_read || bus.data_write) begin
                    w_data_stall      = 1'b1;
                    w_data_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_data_go         = 1'b1;
                w_data_state_next = ST_IDLE;
            end
            default: w_data_state_next = ST_IDLE;
        endcase

        // Reset forces both ports quiet regardless of requests.
        if (rst) begin
            w_inst_stall = 1'b0;
            w_data_stall = 1'b0;
            w_inst_go    = 1'b0;
            w_data_go    = 1'b0;
        end
    end
`else
    assign w_inst_go    = !rst;
    assign w_data_go    = !rst;
    assign w_inst_stall = 1'b0;
    assign w_data_stall = 1'b0;
`endif

    // Registered read data; holds its value when no access completes.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            r_inst_rdata <= 32'h0;
            r_data_rdata <= 32'h0;
        end else begin
            if (w_inst_go && bus.inst_read) begin
                r_inst_rdata <= inst_mem[w_inst_idx];
            end
            // Sampled before the write below lands: read-first on collision.
            if (w_data_go && bus.data_read) begin
                r_data_rdata <= inst_ram[w_data_idx];
            end
        end
    end

    // Array write kept separate so reset never clears storage; w_data_go is
    // already low during reset, so a store presented with rst is dropped.
    always_ff @(posedge clk50M) begin
        if (w_data_go && bus.data_write) begin
            inst_ram[w_data_idx] <= w_data_merged;
        end
    end

    assign bus.inst_rdata = r_inst_rdata;
    assign bus.data_rdata = r_data_rdata;
    assign bus.inst_stall = w_inst_stall;
    assign bus.data_stall = w_data_stall;

endmodule

// File: tb/tb_fake_bus_memory.sv
module tb_fake_bus_memory;

    localparam int AW    = 14;
    localparam int WORDS = 16384;

`ifdef FAKE_BUS_WAIT_EN
    localparam int EXP_WAITS = 1;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic clk;
    logic rst;

    fake_bus_memory_if bus_if();

    fake_bus_memory #(.INST_AW(AW), .DATA_AW(AW)) dut (
        .clk50M (clk),
        .rst    (rst),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain word arrays indexed by (byte address / 4) mod size.
    logic [31:0] m_inst [0:WORDS-1];
    logic [31:0] m_data [0:WORDS-1];
    logic [31:0] last_rd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) % WORDS);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // One data-port transaction; starts and ends 1 time unit after a rising edge.
    task automatic data_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd,
                             output logic [31:0] dw, output logic [31:0] rdata,
                             output int waits);
        logic st;
        logic done;
        bus_if.data_read       = rd;
        bus_if.data_write      = wr;
        bus_if.data_address    = addr;
        bus_if.data_byteenable = be;
        bus_if.data_wdata      = wd;
        #1 dw = bus_if.data_w;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            st = bus_if.data_stall;
            @(posedge clk);
            #1;
            if (!st) done = 1'b1;
            else begin
                waits++;
                if (waits > 4) begin
                    waits = 99;
                    done  = 1'b1;
                end
            end
        end
        rdata = bus_if.data_rdata;
        bus_if.data_read  = 1'b0;
        bus_if.data_write = 1'b0;
        $display("data rd=%0b wr=%0b addr=%h be=%b wd=%h -> data_w=%h rdata=%h waits=%0d",
                 rd, wr, addr, be, wd, dw, rdata, waits);
    endtask

    task automatic inst_xfer(input logic [31:0] addr, output logic [31:0] rdata,
                             output int waits);
        logic st;
        logic done;
        bus_if.inst_read    = 1'b1;
        bus_if.inst_address = addr;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            st = bus_if.inst_stall;
            @(posedge clk);
            #1;
            if (!st) done = 1'b1;
            else begin
                waits++;
                if (waits > 4) begin
                    waits = 99;
                    done  = 1'b1;
                end
            end
        end
        rdata = bus_if.inst_rdata;
        bus_if.inst_read = 1'b0;
        $display("inst addr=%h -> rdata=%h waits=%0d", addr, rdata, waits);
    endtask

    task automatic test_reset();
        total_cnt++;
        if (bus_if.inst_rdata !== 32'h0) $display("FAIL reset_inst_rdata: got %h expected %h", bus_if.inst_rdata, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.data_rdata !== 32'h0) $display("FAIL reset_data_rdata: got %h expected %h", bus_if.data_rdata, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.inst_stall !== 1'b0) $display("FAIL reset_inst_stall: got %b expected 0", bus_if.inst_stall);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.data_stall !== 1'b0) $display("FAIL reset_data_stall: got %b expected 0", bus_if.data_stall);
        else pass_cnt++;
        $display("reset checked");
    endtask

    task automatic test_inst_fetch();
        logic [31:0] rd;
        logic [31:0] addr;
        int w;
        inst_xfer(32'h0, rd, w);
        total_cnt++;
        if (rd !== 32'h34011100) $display("FAIL inst_fetch0: got %h expected %h", rd, 32'h34011100);
        else pass_cnt++;
        total_cnt++;
        if (w !== EXP_WAITS) $display("FAIL inst_waits0: got %0d expected %0d", w, EXP_WAITS);
        else pass_cnt++;
        inst_xfer(32'h4, rd, w);
        total_cnt++;
        if (rd !== 32'h34020020) $display("FAIL inst_fetch4: got %h expected %h", rd, 32'h34020020);
        else pass_cnt++;
        // No request: output holds.
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++;
        if (bus_if.inst_rdata !== 32'h34020020) $display("FAIL inst_hold: got %h expected %h", bus_if.inst_rdata, 32'h34020020);
        else pass_cnt++;
        // Random fetches with junk upper and low address bits (wrap).
        for (int i = 0; i < 10; i++) begin
            addr = ($urandom_range(0, 63) << 2) | ($urandom_range(0, 7) << 16) | $urandom_range(0, 3);
            inst_xfer(addr, rd, w);
            total_cnt++;
            if (rd !== m_inst[widx(addr)]) $display("FAIL inst_rand: addr %h got %h expected %h", addr, rd, m_inst[widx(addr)]);
            else pass_cnt++;
            total_cnt++;
            if (w !== EXP_WAITS) $display("FAIL inst_rand_waits: got %0d expected %0d", w, EXP_WAITS);
            else pass_cnt++;
        end
    endtask

    task automatic test_data_write_read();
        logic [31:0] dw;
        logic [31:0] rd;
        int w;
        data_xfer(1'b0, 1'b1, 32'h10, 4'b1111, 32'h44332211, dw, rd, w);
        m_data[widx(32'h10)] = 32'h44332211;
        total_cnt++;
        if (dw !== 32'h44332211) $display("FAIL full_write_tap: got %h expected %h", dw, 32'h44332211);
        else pass_cnt++;
        total_cnt++;
        if (w !== EXP_WAITS) $display("FAIL write_waits: got %0d expected %0d", w, EXP_WAITS);
        else pass_cnt++;
        data_xfer(1'b1, 1'b0, 32'h10, 4'b0000, 32'h0, dw, rd, w);
        last_rd = rd;
        total_cnt++;
        if (rd !== 32'h44332211) $display("FAIL full_write_read: got %h expected %h", rd, 32'h44332211);
        else pass_cnt++;
        total_cnt++;
        if (dw !== 32'h0) $display("FAIL tap_idle: got %h expected %h", dw, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (w !== EXP_WAITS) $display("FAIL read_waits: got %0d expected %0d", w, EXP_WAITS);
        else pass_cnt++;
    endtask

    task automatic test_partial_write();
        logic [31:0] dw;
        logic [31:0] rd;
        int w;
        data_xfer(1'b0, 1'b1, 32'h10, 4'b0010, 32'h0000AA00, dw, rd, w);
        total_cnt++;
        if (dw !== 32'h4433AA11) $display("FAIL partial_tap: got %h expected %h", dw, 32'h4433AA11);
        else pass_cnt++;
        m_data[widx(32'h10)] = merge(m_data[widx(32'h10)], 32'h0000AA00, 4'b0010);
        total_cnt++;
        if (dut.inst_ram[4] !== 32'h4433AA11) $display("FAIL partial_store: got %h expected %h", dut.inst_ram[4], 32'h4433AA11);
        else pass_cnt++;
        total_cnt++;
        if (rd !== last_rd) $display("FAIL rdata_hold_on_write: got %h expected %h", rd, last_rd);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] dw;
        logic [31:0] rd;
        int w;
        data_xfer(1'b0, 1'b1, 32'h10000, 4'b1111, 32'hDEADBEEF, dw, rd, w);
        m_data[widx(32'h10000)] = 32'hDEADBEEF;
        total_cnt++;
        if (dut.inst_ram[0] !== 32'hDEADBEEF) $display("FAIL wrap_store: got %h expected %h", dut.inst_ram[0], 32'hDEADBEEF);
        else pass_cnt++;
        data_xfer(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, dw, rd, w);
        last_rd = rd;
        total_cnt++;
        if (rd !== m_data[0]) $display("FAIL wrap_read: got %h expected %h", rd, m_data[0]);
        else pass_cnt++;
    endtask

    task automatic test_random_data();
        logic [31:0] dw;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_dw;
        logic [31:0] exp_rd;
        logic [3:0]  be;
        logic        r;
        logic        wr;
        int          op;
        int          w;
        for (int i = 0; i < 40; i++) begin
            addr = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 3) << 16) | $urandom_range(0, 3);
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            op   = $urandom_range(0, 2);
            r    = (op != 1);
            wr   = (op != 0);
            exp_dw = wr ? merge(m_data[widx(addr)], wd, be) : 32'h0;
            exp_rd = r ? m_data[widx(addr)] : last_rd;     // read-first on collision
            data_xfer(r, wr, addr, be, wd, dw, rd, w);
            if (wr) m_data[widx(addr)] = exp_dw;
            last_rd = exp_rd;
            total_cnt++;
            if (dw !== exp_dw) $display("FAIL rand_tap: addr %h got %h expected %h", addr, dw, exp_dw);
            else pass_cnt++;
            total_cnt++;
            if (rd !== exp_rd) $display("FAIL rand_rdata: addr %h got %h expected %h", addr, rd, exp_rd);
            else pass_cnt++;
            total_cnt++;
            if (w !== EXP_WAITS) $display("FAIL rand_waits: got %0d expected %0d", w, EXP_WAITS);
            else pass_cnt++;
        end
        // Sweep the touched words to confirm final storage.
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (dut.inst_ram[k] !== m_data[k]) $display("FAIL rand_store: word %0d got %h expected %h", k, dut.inst_ram[k], m_data[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_with_write();
        logic [31:0] exp_dw;
        logic [31:0] wd;
        wd = 32'hCAFE5A5A;
        exp_dw = merge(m_data[widx(32'h20)], wd, 4'b1111);
        rst = 1'b1;
        bus_if.data_read       = 1'b1;
        bus_if.data_write      = 1'b1;
        bus_if.data_address    = 32'h20;
        bus_if.data_byteenable = 4'b1111;
        bus_if.data_wdata      = wd;
        bus_if.inst_read       = 1'b1;
        bus_if.inst_address    = 32'h4;
        #1;
        total_cnt++;
        if (bus_if.data_w !== exp_dw) $display("FAIL rst_tap: got %h expected %h", bus_if.data_w, exp_dw);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.data_stall !== 1'b0) $display("FAIL rst_data_stall: got %b expected 0", bus_if.data_stall);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.inst_stall !== 1'b0) $display("FAIL rst_inst_stall: got %b expected 0", bus_if.inst_stall);
        else pass_cnt++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total_cnt++;
        if (dut.inst_ram[8] !== m_data[8]) $display("FAIL rst_no_write: got %h expected %h", dut.inst_ram[8], m_data[8]);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.data_rdata !== 32'h0) $display("FAIL rst_data_rdata: got %h expected %h", bus_if.data_rdata, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.inst_rdata !== 32'h0) $display("FAIL rst_inst_rdata: got %h expected %h", bus_if.inst_rdata, 32'h0);
        else pass_cnt++;
        bus_if.data_read  = 1'b0;
        bus_if.data_write = 1'b0;
        bus_if.inst_read  = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset during write checked");
    endtask

    initial begin
        rst = 1'b1;
        bus_if.inst_read       = 1'b0;
        bus_if.inst_address    = 32'h0;
        bus_if.data_read       = 1'b0;
        bus_if.data_write      = 1'b0;
        bus_if.data_address    = 32'h0;
        bus_if.data_byteenable = 4'h0;
        bus_if.data_wdata      = 32'h0;
        last_rd = 32'h0;

        for (int i = 0; i < WORDS; i++) begin
            m_inst[i] = (i < 64) ? 32'($urandom) : 32'h0;
            m_data[i] = 32'h0;
        end
        m_inst[0] = 32'h34011100;
        m_inst[1] = 32'h34020020;
        m_inst[2] = 32'h34030030;
        m_inst[3] = 32'h34040040;
        for (int i = 0; i < WORDS; i++) begin
            dut.inst_mem[i] = m_inst[i];
            dut.inst_ram[i] = m_data[i];
        end

        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;

        test_inst_fetch();
        test_data_write_read();
        test_partial_write();
        test_wrap();
        test_random_data();
        test_reset_with_write();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fake_bus_memory.md
# fake_bus_memory

Simulation-only behavioural memory serving a CPU core's two bus masters: a read-only instruction port and a read/write data port, each a zero-wait-state word-addressed slave. It replaces FPGA block RAM and the SoC interconnect in CPU-level testbenches. Memory contents are preloaded or cleared by the bench through hierarchical access, and the data port exposes a write-observation tap that the bench uses to check committed stores.

## Interface
- INST_AW, 14: instruction memory address width in words (16384 words).
- DATA_AW, 14: data memory address width in words.
- clk50M  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- inst_read  in  1  instruction fetch request.
- inst_address  in  32  byte address; bits [1:0] ignored.
- inst_rdata  out  32  fetched word.
- inst_stall  out  1  fetch not yet complete.
- data_read  in  1  data read request.
- data_write  in  1  data write request.
- data_address  in  32  byte address; bits [1:0] ignored.
- data_byteenable  in  4  per-byte write enable; bit i selects bits [8i+7:8i].
- data_wdata  in  32  write data, byte lanes already aligned.
- data_rdata  out  32  read word.
- data_stall  out  1  data access not yet complete.
- data_w  out  32  write-observation tap: the merged word being committed this cycle.

## Operation
- Storage:
  - inst_mem[0:2^INST_AW-1] and inst_ram[0:2^DATA_AW-1] are 32-bit arrays with exactly these hierarchical names.
  - Both arrays are writable by bench $readmemh and direct assignment.
  - Reset never clears either array.
- Indexing:
  - Word index is address[AW+1:2].
  - Upper address bits are ignored, so addresses wrap modulo the memory size.
- Instruction port: read-only; it has no write path.
- Data write (data_write=1):
  - New word = old word with each enabled byte lane replaced from data_wdata.
  - Byte-enable 4'b0000 leaves the word unchanged.
- data_w:
  - Combinationally equals the merged word for the current address whenever data_write=1.
  - Otherwise data_w is 0.
- data_read together with data_write at the same address: the write commits and data_rdata returns the pre-write word (read-first).
- Reads of never-written, uninitialised words return X. Benches clear the arrays first.

## Timing
- Read latency:
  - Address and request are sampled at the rising edge.
  - inst_rdata and data_rdata are registered and valid from that edge until the next request.
  - With no request, rdata holds its last value.
- Writes commit at the rising edge where data_write=1.
  - A read issued on the next cycle sees the new data.
- Stall outputs are constant 0 unless the wait-state feature is compiled in.
- Reset (rst=1 at the rising edge):
  - inst_rdata=0, data_rdata=0, inst_stall=0, data_stall=0.
  - Any pending wait-state counters clear.
  - Requests presented during reset are ignored: no write, no read capture.
- Reset mid-access abandons the access; the memory array keeps whatever was already committed.

## Configuration
- FAKE_BUS_WAIT_EN, when defined, adds one wait state per access on each port:
  - A new request raises that port's stall for the first cycle.
  - The access completes at the next edge: data is captured or the write is committed, and stall drops.
  - The master must hold address, data, byteenable and request stable while stall=1.
- Undefined: zero wait states, stall tied to 0.

## Test plan
- Preload inst_mem[0..3]={34011100,34020020,...}, release rst, fetch byte addresses 0x0,0x4 -> inst_rdata=0x34011100 then 0x34020020, one edge after each request, inst_stall=0.
- Data write 0x0010 with byteenable=4'b1111 and data_wdata=0x44332211, then read 0x0010 -> data_w=0x44332211 during the write, data_rdata=0x44332211.
- Partial write to a word holding 0x44332211 with byteenable=4'b0010 and data_wdata=0x0000AA00 -> data_w and stored word are 0x4433AA11.
- Write 0xDEADBEEF at byte address 0x10000 with DATA_AW=14 -> stored in inst_ram[0] (wrap).
- Assert rst with data_write=1 -> no array change, data_rdata=0, data_w still shows the merged word, both stall outputs 0.
- With FAKE_BUS_WAIT_EN: read request -> data_stall=1 for exactly one cycle, data_rdata valid the following edge.
